// File: rtl/hpi_bus_master_if.sv
// Bundle of the CPU-side request/response port and the CY7C67200 HPI pins.
// The master modport is the hpi_bus_master view; slave is the environment view.
interface hpi_bus_master_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              chip_reset_req;
  logic              busy;
  logic [ADDR_W-1:0] otg_hpi_address;
  logic              otg_hpi_cs;
  logic              otg_hpi_r;
  logic              otg_hpi_w;
  logic              otg_hpi_reset;
  logic [DATA_W-1:0] otg_hpi_data_in;
  logic [DATA_W-1:0] otg_hpi_data_out;
  logic              otg_hpi_data_oe;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, chip_reset_req, otg_hpi_data_in,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output otg_hpi_address, otg_hpi_cs, otg_hpi_r, otg_hpi_w, otg_hpi_reset,
    output otg_hpi_data_out, otg_hpi_data_oe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, chip_reset_req, otg_hpi_data_in,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  otg_hpi_address, otg_hpi_cs, otg_hpi_r, otg_hpi_w, otg_hpi_reset,
    input  otg_hpi_data_out, otg_hpi_data_oe
  );
endinterface

// File: rtl/hpi_bus_master.sv
// HPI master for the CY7C67200: one outstanding request at a time, timed
// setup/strobe/hold phases on the HPI pins, and a timed controller reset pulse.
// Every output is a flop; pin values are computed from the next state.
module hpi_bus_master #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int RST_CYC    = 16,
  parameter int CNT_W      = 8
) (
  input logic              clk_clk,
  input logic              reset_reset_n,
  hpi_bus_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP, CHIPRST} state_t;

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  if (SETUP_CYC < 1 || SETUP_CYC > (1 << CNT_W)) begin : g_bad_setup
    $error("hpi_bus_master: SETUP_CYC out of range");
  end
  if (STROBE_CYC < 1 || STROBE_CYC > (1 << CNT_W)) begin : g_bad_strobe
    $error("hpi_bus_master: STROBE_CYC out of range");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > (1 << CNT_W)) begin : g_bad_hold
    $error("hpi_bus_master: HOLD_CYC out of range");
  end
  if (RST_CYC < 1 || RST_CYC > (1 << CNT_W)) begin : g_bad_rst
    $error("hpi_bus_master: RST_CYC out of range");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              write_q, write_d;
  logic              accept;
  logic              drive_d;

  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_out_q;
  logic              cs_q;
  logic              r_q;
  logic              w_q;
  logic              reset_q;
  logic              oe_q;

  assign bus.req_ready        = req_ready_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_rdata        = rsp_rdata_q;
  assign bus.busy             = busy_q;
  assign bus.otg_hpi_address  = addr_q;
  assign bus.otg_hpi_data_out = data_out_q;
  assign bus.otg_hpi_cs       = cs_q;
  assign bus.otg_hpi_r        = r_q;
  assign bus.otg_hpi_w        = w_q;
  assign bus.otg_hpi_reset    = reset_q;
  assign bus.otg_hpi_data_oe  = oe_q;

  // Next-state, phase counter, sticky reset request and latched direction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q || bus.chip_reset_req) begin
          state_d = CHIPRST;
          cnt_d   = RST_LOAD;
        end else if (bus.req_valid && req_ready_q) begin
          accept  = 1'b1;
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: begin
        if (pending_q || bus.chip_reset_req) begin
          state_d = CHIPRST;
          cnt_d   = RST_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      CHIPRST: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Clearing on entry to CHIPRST takes priority: a request arriving in the
    // same cycle is the one being serviced.
    pending_d = pending_q;
    if (state_d == CHIPRST && state_q != CHIPRST) begin
      pending_d = 1'b0;
    end else if (bus.chip_reset_req && state_q != IDLE) begin
      pending_d = 1'b1;
    end

    write_d = accept ? bus.req_write : write_q;
    drive_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      data_out_q  <= '0;
      cs_q        <= 1'b1;
      r_q         <= 1'b1;
      w_q         <= 1'b1;
      reset_q     <= 1'b1;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      write_q     <= write_d;
      req_ready_q <= (state_d == IDLE) && !pending_d;
      rsp_valid_q <= (state_d == RESP);
      busy_q      <= (state_d != IDLE) || pending_d;
      cs_q        <= !drive_d;
      r_q         <= !((state_d == STROBE) && !write_d);
      w_q         <= !((state_d == STROBE) && write_d);
      reset_q     <= (state_d != CHIPRST);
      oe_q        <= drive_d && write_d;
      if (accept) begin
        addr_q     <= bus.req_addr;
        data_out_q <= bus.req_wdata;
      end
      if (state_q == STROBE && state_d == HOLD && !write_q) begin
        rsp_rdata_q <= bus.otg_hpi_data_in;
      end
    end
  end

endmodule
